multicycle_sequencer: RTL

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/instr_class_decode.sv | 31 +++
 rtl/multicycle_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// instruction class codes and the special halt/timeout constants.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_SPC = 2'b11;

  localparam logic [8:0] HALT_INSTR  = 9'h1FF;
  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

endpackage

// File: rtl/instr_class_decode.sv
// Splits the IR into one-hot class flags plus store and halt qualifiers.
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [8:0] instruction,
  output logic       is_alu,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt
);

  always_comb begin
    is_alu    = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_halt   = (instruction == HALT_INSTR);
    case (instruction[8:7])
      CLS_ALU: is_alu = 1'b1;
      CLS_MEM: begin
        is_mem   = 1'b1;
        is_store = instruction[6];
      end
      CLS_BR:  is_branch = 1'b1;
      CLS_SPC: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory wait timeout, and a saturating retired-instruction counter.
module multicycle_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  instruction,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        alu_op,
  output logic        branch,
  output logic        reg_write,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        done,
  output logic        err,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] retired_q, retired_d;
  logic        err_q, err_d;

  logic is_alu, is_mem, is_store, is_branch, is_halt;

  instr_class_decode u_decode (
    .instruction (instruction),
    .is_alu      (is_alu),
    .is_mem      (is_mem),
    .is_store    (is_store),
    .is_branch   (is_branch),
    .is_halt     (is_halt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  // The wait counter defaults to zero so it is already clear on any entry
  // into FETCH or MEM; it only advances while a request sits unacknowledged.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    retired_d = retired_q;
    err_d     = err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          retired_d = '0;
          err_d     = 1'b0;
        end
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end else if (wait_q == MEM_TIMEOUT) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: state_d = is_halt ? HALT : EXEC;
      EXEC: begin
        alu_op = 1'b1;
        if (is_alu) begin
          state_d = WB;
        end else if (is_mem) begin
          state_d = MEM;
        end else if (is_branch) begin
          branch  = 1'b1;
          pc_load = ~alu_zero;
          pc_inc  = alu_zero;
          state_d = FETCH;
        end else begin
          pc_inc  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_q == MEM_TIMEOUT) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        state_d   = FETCH;
      end
      HALT: begin
        done = 1'b1;
        if (start) begin
          state_d   = FETCH;
          retired_d = '0;
          err_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((pc_inc || pc_load) && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  assign err     = err_q;
  assign retired = retired_q;

endmodule
